// File: rtl/maze_path_reader.sv
// Drains the solver's path stack and replays it source-to-destination.
// Optional endpoint/wrap checking is enabled with PATH_CHECK_EN.
module maze_path_reader #(
    parameter int MAX_LEN = 256,
    parameter int LEN_W   = 9,
    parameter int COORD_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stk_empty,
    input  logic [1:0]         stk_dout,
    output logic               stk_pop,
    output logic               mv_valid,
    input  logic               mv_ready,
    output logic [1:0]         mv_dir,
    output logic [COORD_W-1:0] mv_row,
    output logic [COORD_W-1:0] mv_col,
    output logic               busy,
    output logic               done,
    output logic [LEN_W-1:0]   path_len,
    output logic               overflow,
    output logic               path_err
);

    typedef enum logic [1:0] {IDLE, DRAIN, EMIT, FIN} state_t;

    state_t state, state_n;

    logic [LEN_W-1:0]   cnt;
    logic [LEN_W-2:0]   idx;
    logic [1:0]         pbuf [MAX_LEN];
    logic [COORD_W-1:0] row, col;
    logic [COORD_W-1:0] nrow, ncol;
    logic [1:0]         bdir;
    logic               full;
    logic               accept;

    assign full   = (cnt == LEN_W'(MAX_LEN));
    assign accept = mv_valid && mv_ready;
    assign bdir   = pbuf[idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (start) state_n = DRAIN;
            DRAIN: begin
                if (stk_empty)
                    state_n = (cnt == '0) ? FIN : EMIT;
                else if (full)
                    state_n = FIN;
            end
            EMIT:  if (accept && idx == '0) state_n = FIN;
            FIN:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        stk_pop = (state == DRAIN) && !stk_empty && !full;
        busy    = (state != IDLE);
        done    = (state == FIN);
    end

    // Position after applying the buffered direction to the current cell
    always_comb begin
        nrow = row;
        ncol = col;
        unique case (bdir)
            2'b00: nrow = row - 1'b1;
            2'b01: ncol = col + 1'b1;
            2'b10: ncol = col - 1'b1;
            2'b11: nrow = row + 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (stk_pop) pbuf[cnt[LEN_W-2:0]] <= stk_dout;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            idx      <= '0;
            row      <= '0;
            col      <= '0;
            mv_valid <= 1'b0;
            mv_dir   <= '0;
            mv_row   <= '0;
            mv_col   <= '0;
            path_len <= '0;
            overflow <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                cnt      <= '0;
                row      <= '0;
                col      <= '0;
                path_len <= '0;
                overflow <= 1'b0;
            end
            if (state == DRAIN) begin
                if (stk_pop) cnt <= cnt + 1'b1;
                if (stk_empty) idx <= cnt[LEN_W-2:0] - 1'b1;
                if (!stk_empty && full) overflow <= 1'b1;
            end
            if (state == EMIT) begin
                if (!mv_valid) begin
                    mv_valid <= 1'b1;
                    mv_dir   <= bdir;
                    mv_row   <= nrow;
                    mv_col   <= ncol;
                end else if (mv_ready) begin
                    mv_valid <= 1'b0;
                    row      <= mv_row;
                    col      <= mv_col;
                    idx      <= idx - 1'b1;
                end
            end
            // Length is visible alongside done
            if (state != FIN && state_n == FIN) path_len <= cnt;
        end
    end

`ifdef PATH_CHECK_EN
    logic wrap;
    logic err_set;

    always_comb begin
        wrap = 1'b0;
        unique case (mv_dir)
            2'b00: wrap = (row == '0);
            2'b01: wrap = (col == '1);
            2'b10: wrap = (col == '0);
            2'b11: wrap = (row == '1);
            default: ;
        endcase
    end

    // Leaving DRAIN straight to FIN means empty or overflowed path
    always_comb begin
        err_set = 1'b0;
        if (state == EMIT && accept && wrap)
            err_set = 1'b1;
        if (state == DRAIN && state_n == FIN)
            err_set = 1'b1;
        if (state == EMIT && state_n == FIN &&
            {mv_row, mv_col} != '1)
            err_set = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            path_err <= 1'b0;
        else if (state == IDLE && start)
            path_err <= 1'b0;
        else if (err_set)
            path_err <= 1'b1;
    end
`else
    assign path_err = 1'b0;
`endif

endmodule
